// File: rtl/ser_seq_pkg.sv
// Shared state encoding, serializer select codes and default patterns
// for the serializer lane sequencer.
package ser_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CLKPAT = 3'd2,
      ST_PRBS   = 3'd3,
      ST_SYNC   = 3'd4,
      ST_RUN    = 3'd5
   } seq_state_t;

   localparam logic [1:0] SEL_CLK  = 2'b00;
   localparam logic [1:0] SEL_DATA = 2'b01;
   localparam logic [1:0] SEL_PRBS = 2'b10;
   localparam logic [1:0] SEL_LOW  = 2'b11;

   localparam logic [19:0] DEF_SYNC_WORD = 20'hAF0F5;
   localparam logic [19:0] DEF_IDLE_WORD = 20'h55555;

   // Select code driven on an enabled lane in the given state.
   function automatic logic [1:0] sel_for_state(input seq_state_t st);
      logic [1:0] sel;
      case (st)
         ST_CLKPAT:       sel = SEL_CLK;
         ST_PRBS:         sel = SEL_PRBS;
         ST_SYNC, ST_RUN: sel = SEL_DATA;
         default:         sel = SEL_LOW;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ser_seq_lane_mux.sv
// One serializer lane: word mux (data/sync/idle/zero) plus the registered
// enable, select, ready and word outputs, all loaded from next-cycle state.
module ser_seq_lane_mux
   import ser_seq_pkg::*;
#(
   parameter int                WORD_W    = 20,
   parameter logic [WORD_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
   parameter logic [WORD_W-1:0] IDLE_WORD = DEF_IDLE_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lane_on,
   input  seq_state_t        state,
   input  seq_state_t        next_state,
   input  logic              slot_zero,
   input  logic              next_slot_zero,
   input  logic [WORD_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [WORD_W-1:0] data_ser,
   output logic              en_lane,
   output logic [1:0]        sel
);

   logic              ready_d;
   logic              en_d;
   logic [1:0]        sel_d;
   logic [WORD_W-1:0] word_d;

   // Each RUN slot's word leaves one cycle after the slot itself, the same
   // latency as accepted data; the first RUN cycle therefore carries filler.
   always_comb begin
      ready_d = 1'b0;
      en_d    = 1'b0;
      sel_d   = SEL_LOW;
      word_d  = {WORD_W{1'b0}};
      if (lane_on && (next_state != ST_IDLE)) begin
         en_d    = 1'b1;
         sel_d   = sel_for_state(next_state);
         ready_d = (next_state == ST_RUN) && !next_slot_zero;
         if (next_state == ST_SYNC) begin
            word_d = SYNC_WORD;
         end else if (next_state == ST_RUN) begin
            if (state != ST_RUN) begin
               word_d = IDLE_WORD;
            end else if (slot_zero) begin
               word_d = SYNC_WORD;
            end else if (data_valid && data_ready) begin
               word_d = data_in;
            end else begin
               word_d = IDLE_WORD;
            end
         end else begin
            word_d = {WORD_W{1'b0}};
         end
      end else begin
         en_d = 1'b0;
      end
   end

   // Lane output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_ready <= 1'b0;
         data_ser   <= {WORD_W{1'b0}};
         en_lane    <= 1'b0;
         sel        <= SEL_LOW;
      end else begin
         data_ready <= ready_d;
         data_ser   <= word_d;
         en_lane    <= en_d;
         sel        <= sel_d;
      end
   end

endmodule

// File: rtl/ser_lane_sequencer.sv
// Bring-up and run-mode sequencer for the four-lane 20:1 serializer:
// FSM, phase counter, run-mode slot counter and the per-lane muxes.
module ser_lane_sequencer
   import ser_seq_pkg::*;
#(
   parameter int                NUM_LANES     = 4,
   parameter int                WORD_W        = 20,
   parameter int                SETTLE_WORDS  = 16,
   parameter int                CLKPAT_WORDS  = 64,
   parameter int                PRBS_WORDS    = 1024,
   parameter int                SYNC_WORDS    = 32,
   parameter int                SYNC_INTERVAL = 32,
   parameter logic [WORD_W-1:0] SYNC_WORD     = DEF_SYNC_WORD,
   parameter logic [WORD_W-1:0] IDLE_WORD     = DEF_IDLE_WORD
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_LANES-1:0]        CFG_EN_LANE,
   input  logic                        CFG_START,
   input  logic                        CFG_STOP,
   input  logic [NUM_LANES*WORD_W-1:0] DATA_IN,
   input  logic [NUM_LANES-1:0]        DATA_VALID,
   output logic [NUM_LANES-1:0]        DATA_READY,
   output logic [NUM_LANES*WORD_W-1:0] DATA_SER,
   output logic [NUM_LANES-1:0]        EN_LANE,
   output logic [2*NUM_LANES-1:0]      SER_SEL_OUT,
   output logic                        LANES_UP,
   output logic [2:0]                  STATE
);

   localparam int MAX_A   = (SETTLE_WORDS > CLKPAT_WORDS) ? SETTLE_WORDS : CLKPAT_WORDS;
   localparam int MAX_B   = (PRBS_WORDS > SYNC_WORDS) ? PRBS_WORDS : SYNC_WORDS;
   localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int PHASE_W = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);
   localparam int SLOT_W  = ($clog2(SYNC_INTERVAL) < 1) ? 1 : $clog2(SYNC_INTERVAL);

   localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_WORDS - 1);
   localparam logic [PHASE_W-1:0] CLKPAT_LAST = PHASE_W'(CLKPAT_WORDS - 1);
   localparam logic [PHASE_W-1:0] PRBS_LAST   = PHASE_W'(PRBS_WORDS - 1);
   localparam logic [PHASE_W-1:0] SYNC_LAST   = PHASE_W'(SYNC_WORDS - 1);
   localparam logic [SLOT_W-1:0]  SLOT_LAST   = SLOT_W'(SYNC_INTERVAL - 1);

   seq_state_t           state;
   seq_state_t           next_state;
   logic [PHASE_W-1:0]   phase;
   logic [PHASE_W-1:0]   next_phase;
   logic [SLOT_W-1:0]    slot;
   logic [SLOT_W-1:0]    next_slot;
   logic [NUM_LANES-1:0] lane_mask;
   logic [NUM_LANES-1:0] next_mask;
   logic                 start_ok;
   logic                 lanes_up;

   // Next-state, phase, slot and lane-mask logic; STOP overrides everything.
   always_comb begin
      next_state = state;
      start_ok   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (CFG_START && (CFG_EN_LANE != {NUM_LANES{1'b0}})) begin
               next_state = ST_SETTLE;
               start_ok   = 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_SETTLE: next_state = (phase == SETTLE_LAST) ? ST_CLKPAT : ST_SETTLE;
         ST_CLKPAT: next_state = (phase == CLKPAT_LAST) ? ST_PRBS   : ST_CLKPAT;
         ST_PRBS:   next_state = (phase == PRBS_LAST)   ? ST_SYNC   : ST_PRBS;
         ST_SYNC:   next_state = (phase == SYNC_LAST)   ? ST_RUN    : ST_SYNC;
         ST_RUN:    next_state = ST_RUN;
         default:   next_state = ST_IDLE;
      endcase
      if (CFG_STOP) begin
         next_state = ST_IDLE;
         start_ok   = 1'b0;
      end else begin
         start_ok   = start_ok;
      end

      if (CFG_STOP) begin
         next_mask = {NUM_LANES{1'b0}};
      end else if (start_ok) begin
         next_mask = CFG_EN_LANE;
      end else begin
         next_mask = lane_mask;
      end

      if ((next_state != state) || (state == ST_IDLE) || (state == ST_RUN)) begin
         next_phase = {PHASE_W{1'b0}};
      end else begin
         next_phase = phase + 1'b1;
      end

      // The slot counter is shared by all lanes so sync slots stay aligned.
      if ((next_state == ST_RUN) && (state == ST_RUN)) begin
         next_slot = (slot == SLOT_LAST) ? {SLOT_W{1'b0}} : slot + 1'b1;
      end else begin
         next_slot = {SLOT_W{1'b0}};
      end
   end

   // State, counters and mask registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         phase     <= {PHASE_W{1'b0}};
         slot      <= {SLOT_W{1'b0}};
         lane_mask <= {NUM_LANES{1'b0}};
         lanes_up  <= 1'b0;
      end else begin
         state     <= next_state;
         phase     <= next_phase;
         slot      <= next_slot;
         lane_mask <= next_mask;
         lanes_up  <= (next_state == ST_RUN);
      end
   end

   assign STATE    = state;
   assign LANES_UP = lanes_up;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ser_seq_lane_mux #(
         .WORD_W    (WORD_W),
         .SYNC_WORD (SYNC_WORD),
         .IDLE_WORD (IDLE_WORD)
      ) u_lane (
         .clk            (CLK),
         .rst            (RST),
         .lane_on        (next_mask[i]),
         .state          (state),
         .next_state     (next_state),
         .slot_zero      (slot == {SLOT_W{1'b0}}),
         .next_slot_zero (next_slot == {SLOT_W{1'b0}}),
         .data_in        (DATA_IN[i*WORD_W +: WORD_W]),
         .data_valid     (DATA_VALID[i]),
         .data_ready     (DATA_READY[i]),
         .data_ser       (DATA_SER[i*WORD_W +: WORD_W]),
         .en_lane        (EN_LANE[i]),
         .sel            (SER_SEL_OUT[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_ser_lane_sequencer.sv
// Directed, table-driven bench for ser_lane_sequencer: config handshake
// vectors, bring-up durations, run-mode sync/idle/data slots, stop and reset.
module tb_ser_lane_sequencer;

   localparam int NL = 4;
   localparam int WW = 20;
   localparam logic [19:0] SYNC_W = 20'hAF0F5;
   localparam logic [19:0] IDLE_W = 20'h55555;

   logic             clk = 1'b0;
   logic             rst;
   logic [NL-1:0]    cfg_en_lane;
   logic             cfg_start;
   logic             cfg_stop;
   logic [NL*WW-1:0] data_in;
   logic [NL-1:0]    data_valid;
   logic [NL-1:0]    data_ready;
   logic [NL*WW-1:0] data_ser;
   logic [NL-1:0]    en_lane;
   logic [2*NL-1:0]  ser_sel;
   logic             lanes_up;
   logic [2:0]       state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ser_lane_sequencer dut (
      .CLK         (clk),
      .RST         (rst),
      .CFG_EN_LANE (cfg_en_lane),
      .CFG_START   (cfg_start),
      .CFG_STOP    (cfg_stop),
      .DATA_IN     (data_in),
      .DATA_VALID  (data_valid),
      .DATA_READY  (data_ready),
      .DATA_SER    (data_ser),
      .EN_LANE     (en_lane),
      .SER_SEL_OUT (ser_sel),
      .LANES_UP    (lanes_up),
      .STATE       (state)
   );

   typedef struct {
      logic       start;
      logic       stop;
      logic [3:0] mask;
      logic [2:0] exp_state;
      logic [3:0] exp_en;
      logic [7:0] exp_sel;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".state"}, 64'(state), 64'd0);
      chk({tag, ".en"}, 64'(en_lane), 64'd0);
      chk({tag, ".sel"}, 64'(ser_sel), 64'hFF);
      chk({tag, ".data"}, 64'(|data_ser), 64'd0);
      chk({tag, ".ready"}, 64'(data_ready), 64'd0);
      chk({tag, ".up"}, 64'(lanes_up), 64'd0);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      for (int c = 0; c < budget && state != s; c++) step();
      chk(tag, 64'(state), 64'(s));
   endtask

   // Start with mask 0101 and follow the sequence up to the first RUN cycle.
   task automatic bringup(input string tag);
      int cnt[8];
      int bad;
      logic [2:0] prev;
      logic [1:0] es;
      bad = 0;
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      cfg_en_lane = 4'b0101;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_en_lane = 4'b1111;
      chk({tag, ".first_state"}, 64'(state), 64'd1);
      prev = 3'd1;
      for (int c = 0; c < 1200 && state != 3'd5; c++) begin
         if (state != prev && state != prev + 3'd1) bad++;
         prev = state;
         cnt[state]++;
         case (state)
            3'd2:    es = 2'b00;
            3'd3:    es = 2'b10;
            3'd4:    es = 2'b01;
            default: es = 2'b11;
         endcase
         if (ser_sel[1:0] != es || ser_sel[5:4] != es) bad++;
         if (ser_sel[3:2] != 2'b11 || ser_sel[7:6] != 2'b11) bad++;
         if (en_lane != 4'b0101 || data_ready != 4'b0000 || lanes_up) bad++;
         if (data_ser[39:20] != 20'd0 || data_ser[79:60] != 20'd0) bad++;
         if (state == 3'd4) begin
            if (data_ser[19:0] != SYNC_W || data_ser[59:40] != SYNC_W) bad++;
         end else begin
            if (data_ser[19:0] != 20'd0 || data_ser[59:40] != 20'd0) bad++;
         end
         step();
      end
      chk({tag, ".reach_run"}, 64'(state), 64'd5);
      chk({tag, ".settle_len"}, 64'(cnt[1]), 64'd16);
      chk({tag, ".clkpat_len"}, 64'(cnt[2]), 64'd64);
      chk({tag, ".prbs_len"}, 64'(cnt[3]), 64'd1024);
      chk({tag, ".sync_len"}, 64'(cnt[4]), 64'd32);
      chk({tag, ".per_cycle_bad"}, 64'(bad), 64'd0);
      chk({tag, ".run_sel"}, 64'(ser_sel), 64'hDD);
      chk({tag, ".run_en"}, 64'(en_lane), 64'h5);
      chk({tag, ".lanes_up"}, 64'(lanes_up), 64'd1);
   endtask

   initial begin
      logic [19:0] exp0;
      logic [19:0] exp2;
      logic [19:0] dval;
      int slot;
      logic v;

      vecs[0] = '{1'b1, 1'b0, 4'b0000, 3'd0, 4'b0000, 8'hFF};
      vecs[1] = '{1'b0, 1'b1, 4'b0000, 3'd0, 4'b0000, 8'hFF};
      vecs[2] = '{1'b1, 1'b1, 4'b0101, 3'd0, 4'b0000, 8'hFF};
      vecs[3] = '{1'b1, 1'b0, 4'b0101, 3'd1, 4'b0101, 8'hFF};
      vecs[4] = '{1'b0, 1'b0, 4'b1111, 3'd1, 4'b0101, 8'hFF};
      vecs[5] = '{1'b1, 1'b0, 4'b1111, 3'd1, 4'b0101, 8'hFF};
      vecs[6] = '{1'b0, 1'b1, 4'b0000, 3'd0, 4'b0000, 8'hFF};
      vecs[7] = '{1'b1, 1'b0, 4'b0011, 3'd1, 4'b0011, 8'hFF};
      vecs[8] = '{1'b0, 1'b1, 4'b0011, 3'd0, 4'b0000, 8'hFF};

      rst = 1'b1;
      cfg_en_lane = 4'b0000;
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      data_in = '0;
      data_valid = 4'b0000;
      step();
      step();
      chk_quiet("reset");
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         cfg_start = vecs[i].start;
         cfg_stop = vecs[i].stop;
         cfg_en_lane = vecs[i].mask;
         step();
         chk($sformatf("vec%0d.state", i), 64'(state), 64'(vecs[i].exp_state));
         chk($sformatf("vec%0d.en", i), 64'(en_lane), 64'(vecs[i].exp_en));
         chk($sformatf("vec%0d.sel", i), 64'(ser_sel), 64'(vecs[i].exp_sel));
         chk($sformatf("vec%0d.data", i), 64'(|data_ser | |data_ready), 64'd0);
      end
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      step();

      bringup("bring1");

      // RUN: 70 cycles with no valid data, then lane 0 streams counting words.
      exp0 = IDLE_W;
      exp2 = IDLE_W;
      dval = 20'h00100;
      slot = 0;
      for (int r = 0; r < 200; r++) begin
         chk($sformatf("run%0d.lane0", r), 64'(data_ser[19:0]), 64'(exp0));
         chk($sformatf("run%0d.lane2", r), 64'(data_ser[59:40]), 64'(exp2));
         chk($sformatf("run%0d.ready", r), 64'(data_ready), (slot != 0) ? 64'h5 : 64'h0);
         v = (r >= 70);
         data_valid = {3'b000, v};
         data_in[19:0] = dval;
         if (slot == 0) begin
            exp0 = SYNC_W;
            exp2 = SYNC_W;
         end else begin
            exp2 = IDLE_W;
            if (v) begin
               exp0 = dval;
               dval = dval + 20'd1;
            end else begin
               exp0 = IDLE_W;
            end
         end
         slot = (slot == 31) ? 0 : slot + 1;
         step();
      end
      data_valid = 4'b0000;

      cfg_start = 1'b1;
      cfg_en_lane = 4'b1111;
      step();
      cfg_start = 1'b0;
      chk("start_in_run.state", 64'(state), 64'd5);
      chk("start_in_run.en", 64'(en_lane), 64'h5);
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      chk_quiet("stop_run");

      cfg_en_lane = 4'b0101;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      wait_state(3'd3, 200, "reach_prbs");
      step();
      step();
      cfg_start = 1'b1;
      cfg_stop = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      chk_quiet("stop_prbs");
      step();
      chk_quiet("stop_prbs_hold");

      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      wait_state(3'd2, 100, "reach_clkpat");
      step();
      #2 rst = 1'b1;
      #1 chk_quiet("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_rst.state", 64'(state), 64'd0);
      bringup("bring2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
